// File: rtl/line_refill_unit.sv
// Backing store for cache line refills: 64 blocks x 4 B. Each request waits MEM_LATENCY cycles,
// then returns its block as four beats, starting at the missed byte and wrapping within the block.
module line_refill_unit #(
    parameter int MEM_LATENCY  = 2,
    parameter int INIT_PATTERN = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [7:0] req_addr,
    output logic       resp_valid,
    input  logic       resp_ready,
    output logic [7:0] resp_data,
    output logic [1:0] resp_offset,
    output logic       resp_last,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, WAIT, BURST} state_t;

    localparam logic [3:0] LAT_INIT = (MEM_LATENCY == 0) ? 4'd0 : 4'(MEM_LATENCY - 1);

    state_t     state;
    logic [5:0] blk;
    logic [1:0] start;
    logic [1:0] beat;
    logic [3:0] lat_cnt;
    logic [1:0] nxt_off;
    logic [7:0] mem [256];

    // Read-only contents are fixed by elaboration, so reset cannot disturb them.
    for (genvar i = 0; i < 256; i++) begin : g_mem
        assign mem[i] = (INIT_PATTERN != 0) ? 8'(i) : 8'h00;
    end

    assign nxt_off = resp_offset + 2'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            req_ready   <= 1'b0;
            resp_valid  <= 1'b0;
            resp_last   <= 1'b0;
            resp_data   <= 8'h00;
            resp_offset <= 2'd0;
            busy        <= 1'b0;
            lat_cnt     <= 4'd0;
            beat        <= 2'd0;
            blk         <= 6'd0;
            start       <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        blk       <= req_addr[7:2];
                        start     <= req_addr[1:0];
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (MEM_LATENCY == 0) begin
                            state       <= BURST;
                            resp_valid  <= 1'b1;
                            resp_offset <= req_addr[1:0];
                            resp_data   <= mem[req_addr];
                            resp_last   <= 1'b0;
                            beat        <= 2'd0;
                        end else begin
                            state   <= WAIT;
                            lat_cnt <= LAT_INIT;
                        end
                    end else begin
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                WAIT: begin
                    if (lat_cnt == 4'd0) begin
                        state       <= BURST;
                        resp_valid  <= 1'b1;
                        resp_offset <= start;
                        resp_data   <= mem[{blk, start}];
                        resp_last   <= 1'b0;
                        beat        <= 2'd0;
                    end else begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
                end
                BURST: begin
                    if (resp_valid && resp_ready) begin
                        if (beat == 2'd3) begin
                            // req_ready returns only after the last beat, so bursts never overlap.
                            state      <= IDLE;
                            resp_valid <= 1'b0;
                            resp_last  <= 1'b0;
                            req_ready  <= 1'b1;
                            busy       <= 1'b0;
                        end else begin
                            beat        <= beat + 2'd1;
                            resp_offset <= nxt_off;
                            resp_data   <= mem[{blk, nxt_off}];
                            resp_last   <= (beat == 2'd2);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_line_refill_unit.sv
// Directed bench for line_refill_unit: a scoreboard queue of expected beats, filled when a request is
// accepted and drained on each handshake. Two instances cover latencies 2 and 0.
module tb_line_refill_unit;

    typedef struct packed {
        logic [1:0] off;
        logic [7:0] data;
        logic       last;
    } beat_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sel = 1'b0;
    logic       req_valid = 1'b0;
    logic [7:0] req_addr = 8'h00;
    logic       resp_ready = 1'b1;

    logic       rq_rdy2, rs_vld2, rs_last2, busy2;
    logic [7:0] rs_dat2;
    logic [1:0] rs_off2;
    logic       rq_rdy0, rs_vld0, rs_last0, busy0;
    logic [7:0] rs_dat0;
    logic [1:0] rs_off0;

    logic       req_ready, resp_valid, resp_last, busy;
    logic [7:0] resp_data;
    logic [1:0] resp_offset;

    int    checks = 0;
    int    failures = 0;
    beat_t sb[$];

    always #5 clk = ~clk;

    line_refill_unit #(.MEM_LATENCY(2), .INIT_PATTERN(1)) u_lat2 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid & ~sel), .req_ready(rq_rdy2), .req_addr(req_addr),
        .resp_valid(rs_vld2), .resp_ready(resp_ready), .resp_data(rs_dat2),
        .resp_offset(rs_off2), .resp_last(rs_last2), .busy(busy2)
    );

    line_refill_unit #(.MEM_LATENCY(0), .INIT_PATTERN(1)) u_lat0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid & sel), .req_ready(rq_rdy0), .req_addr(req_addr),
        .resp_valid(rs_vld0), .resp_ready(resp_ready), .resp_data(rs_dat0),
        .resp_offset(rs_off0), .resp_last(rs_last0), .busy(busy0)
    );

    assign req_ready   = sel ? rq_rdy0  : rq_rdy2;
    assign resp_valid  = sel ? rs_vld0  : rs_vld2;
    assign resp_last   = sel ? rs_last0 : rs_last2;
    assign resp_data   = sel ? rs_dat0  : rs_dat2;
    assign resp_offset = sel ? rs_off0  : rs_off2;
    assign busy        = sel ? busy0    : busy2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issues one request and consumes nbeats beats, driving resp_ready from rpat (then 1).
    // Optionally holds a second request (ign_addr) on the bus for the whole burst.
    task automatic run_req(input logic [7:0] addr, input int lat, input logic [15:0] rpat,
                           input int plen, input int nbeats, input bit ign, input logic [7:0] ign_addr);
        int n, i, hs, cyc;
        bit prev_stall;
        logic [7:0] prev_dat;
        logic [1:0] prev_off;
        beat_t e;
        @(negedge clk);
        req_addr   = addr;
        req_valid  = 1'b1;
        resp_ready = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("accept_%02h", addr), {31'd0, req_ready}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            e.off  = 2'(addr[1:0] + 2'(k));
            e.data = {addr[7:2], e.off};
            e.last = (k == 3);
            sb.push_back(e);
        end
        @(negedge clk);
        req_valid = ign;
        if (ign) req_addr = ign_addr;
        chk($sformatf("rdy_drop_%02h", addr), {31'd0, req_ready}, 32'd0);
        n = 1;
        while (!resp_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("latency_%02h", addr), n, lat + 1);
        i = 0; hs = 0; cyc = 0; prev_stall = 1'b0; prev_dat = '0; prev_off = '0;
        while (hs < nbeats && cyc < 40) begin
            if (prev_stall) begin
                chk($sformatf("stall_dat_%02h", addr), {24'd0, resp_data}, {24'd0, prev_dat});
                chk($sformatf("stall_off_%02h", addr), {30'd0, resp_offset}, {30'd0, prev_off});
            end
            chk($sformatf("burst_rdy_%02h", addr), {31'd0, req_ready}, 32'd0);
            resp_ready = (i < plen) ? rpat[i] : 1'b1;
            i++;
            if (resp_valid && resp_ready && sb.size() > 0) begin
                e = sb.pop_front();
                chk($sformatf("off_%02h_b%0d", addr, hs), {30'd0, resp_offset}, {30'd0, e.off});
                chk($sformatf("dat_%02h_b%0d", addr, hs), {24'd0, resp_data}, {24'd0, e.data});
                chk($sformatf("last_%02h_b%0d", addr, hs), {31'd0, resp_last}, {31'd0, e.last});
                hs++;
            end
            prev_stall = resp_valid && !resp_ready;
            prev_dat   = resp_data;
            prev_off   = resp_offset;
            @(negedge clk);
            cyc++;
        end
        chk($sformatf("handshakes_%02h", addr), hs, nbeats);
        resp_ready = 1'b1;
        if (nbeats == 4) begin
            chk($sformatf("done_vld_%02h", addr), {31'd0, resp_valid}, 32'd0);
            chk($sformatf("done_rdy_%02h", addr), {31'd0, req_ready}, 32'd1);
            chk($sformatf("done_busy_%02h", addr), {31'd0, busy}, 32'd0);
            chk($sformatf("sb_empty_%02h", addr), sb.size(), 0);
        end
        req_valid = 1'b0;
    endtask

    initial begin
        // Reset state and first ready edge
        #2;
        chk("rst_rdy", {31'd0, req_ready}, 32'd0);
        chk("rst_vld", {31'd0, resp_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_dat", {24'd0, resp_data}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rdy_before_edge", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        chk("rdy_after_edge", {31'd0, req_ready}, 32'd1);
        chk("idle_vld", {31'd0, resp_valid}, 32'd0);
        chk("idle_busy", {31'd0, busy}, 32'd0);

        // Latency 2, critical byte 1, always ready
        run_req(8'h01, 2, 16'h0000, 0, 4, 1'b0, 8'h00);
        // Toggling resp_ready: 1,0,0,1,1,0,1
        run_req(8'h72, 2, 16'b1011001, 7, 4, 1'b0, 8'h00);
        // Latency 0, wrap at top of address space
        sel = 1'b1;
        run_req(8'hFF, 0, 16'h0000, 0, 4, 1'b0, 8'h00);
        sel = 1'b0;
        // Second request held during a burst is ignored, then served afterwards
        run_req(8'h10, 2, 16'b0010, 4, 4, 1'b1, 8'h33);
        run_req(8'h33, 2, 16'h0000, 0, 4, 1'b0, 8'h00);

        // Reset while beat 2 is presented
        run_req(8'h04, 2, 16'h0000, 0, 2, 1'b0, 8'h00);
        chk("pre_rst_vld", {31'd0, resp_valid}, 32'd1);
        chk("pre_rst_off", {30'd0, resp_offset}, 32'd2);
        #2 rst = 1'b1;
        #1;
        chk("async_vld", {31'd0, resp_valid}, 32'd0);
        chk("async_busy", {31'd0, busy}, 32'd0);
        chk("async_rdy", {31'd0, req_ready}, 32'd0);
        chk("async_dat", {24'd0, resp_data}, 32'd0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("post_rst_vld_%0d", k), {31'd0, resp_valid}, 32'd0);
        end
        run_req(8'h08, 2, 16'h0000, 0, 4, 1'b0, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
